// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage sitting between the PC register and the IF/ID
// pipeline register. Issues the current PC to instruction memory over a
// req/ready handshake, drives the PC register write enable, and captures the
// returned instruction into IF/ID while honouring stall and flush.
// A one-entry hold buffer keeps an instruction that returns while ID is
// stalled. After a flush with a request still outstanding, the DRAIN state
// finishes that transfer and throws the data away.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   pc_curr     current PC from the PC register
//   pc_write    PC register write enable
//   stall       ID cannot accept; IF/ID holds
//   flush       branch/jump taken; discard the fetch path
//   imem_req    fetch request valid
//   imem_addr   fetch address
//   imem_ready  memory completes the transfer this cycle
//   imem_rdata  fetched instruction
//   ifid_instr  IF/ID instruction
//   ifid_pc4    IF/ID PC+4
//   ifid_valid  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int unsigned    WORD = 32,
    parameter logic [WORD-1:0] NOP = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] pc_curr,
    output logic            pc_write,
    input  logic            stall,
    input  logic            flush,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [WORD-1:0] imem_rdata,
    output logic [WORD-1:0] ifid_instr,
    output logic [WORD-1:0] ifid_pc4,
    output logic            ifid_valid
);

    typedef enum logic [1:0] {
        StReq,
        StHeld,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [WORD-1:0] buf_q, buf_d;
    logic [WORD-1:0] drain_addr_q, drain_addr_d;
    logic [WORD-1:0] instr_q, instr_d;
    logic [WORD-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    logic [WORD-1:0] pc_plus4;

    // Wraps modulo 2^WORD.
    assign pc_plus4 = pc_curr + WORD'(4);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StReq;
            buf_q        <= '0;
            drain_addr_q <= '0;
            instr_q      <= NOP;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (flush > stall > normal in every state)
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        unique case (state_q)
            StReq: begin
                if (flush) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    // Request still in flight: remember its address so it
                    // can be completed and discarded.
                    if (!imem_ready) begin
                        drain_addr_d = pc_curr;
                        state_d      = StDrain;
                    end
                end else if (imem_ready && !stall) begin
                    instr_d = imem_rdata;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end else if (imem_ready) begin
                    buf_d   = imem_rdata;
                    state_d = StHeld;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end

            StHeld: begin
                if (flush) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    state_d = StReq;
                end else if (!stall) begin
                    // PC was not advanced while held, so pc_curr still
                    // matches the buffered instruction.
                    instr_d = buf_q;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    state_d = StReq;
                end
            end

            StDrain: begin
                if (flush) begin
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
                if (imem_ready) begin
                    state_d = StReq;
                end
            end

            default: state_d = StReq;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_write  = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc_curr;

        unique case (state_q)
            StReq: begin
                imem_req = 1'b1;
                pc_write = flush | (imem_ready & ~stall);
            end
            StHeld: begin
                pc_write = flush | ~stall;
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr_q;
                pc_write  = flush;
            end
            default: ;
        endcase

        // Reset is asynchronous: drop the request and PC enable at once.
        if (!reset) begin
            pc_write = 1'b0;
            imem_req = 1'b0;
        end
    end

    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. Expected values are queued as stimulus is
// driven: combinational expectations are compared on the falling edge before
// the active edge, registered expectations 1 time unit after it.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int SInstr = 0;
    localparam int SPc4   = 1;
    localparam int SValid = 2;
    localparam int SPcWr  = 3;
    localparam int SReq   = 4;
    localparam int SAddr  = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc_curr;
    logic        pc_write;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    exp_t pre_q[$];
    exp_t post_q[$];
    int   checks = 0;
    int   errors = 0;

    if_fetch_unit #(
        .WORD (32),
        .NOP  (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_curr    (pc_curr),
        .pc_write   (pc_write),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            SInstr:  return ifid_instr;
            SPc4:    return ifid_pc4;
            SValid:  return {31'd0, ifid_valid};
            SPcWr:   return {31'd0, pc_write};
            SReq:    return {31'd0, imem_req};
            default: return imem_addr;
        endcase
    endfunction

    task automatic compare(exp_t e);
        logic [31:0] obs;
        obs = observe(e.sel);
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", e.tag, obs, e.exp);
        end
    endtask

    // Expect before the next active edge (combinational outputs).
    task automatic ep(string tag, int sel, logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        pre_q.push_back(e);
    endtask

    // Expect after the next active edge (IF/ID register).
    task automatic eq(string tag, int sel, logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        post_q.push_back(e);
    endtask

    task automatic drain_pre();
        exp_t e;
        while (pre_q.size() > 0) begin
            e = pre_q.pop_front();
            compare(e);
        end
    endtask

    task automatic drain_post();
        exp_t e;
        while (post_q.size() > 0) begin
            e = post_q.pop_front();
            compare(e);
        end
    endtask

    task automatic ifid(string tag, logic [31:0] i, logic [31:0] p, logic v);
        eq({tag, "_instr"}, SInstr, i);
        eq({tag, "_pc4"}, SPc4, p);
        eq({tag, "_valid"}, SValid, {31'd0, v});
    endtask

    // One clock: compare queued pre-edge items at negedge, post-edge items
    // just after posedge. Returns at posedge+1, where new inputs are driven.
    task automatic cycle();
        @(negedge clk);
        drain_pre();
        @(posedge clk);
        #1;
        drain_post();
    endtask

    initial begin
        reset      = 1'b0;
        pc_curr    = 32'h0;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0;

        // Reset state: outputs forced low even with ready high.
        #12;
        ep("rst_req", SReq, 32'd0);
        ep("rst_pcwr", SPcWr, 32'd0);
        ifid("rst", 32'h0, 32'h0, 1'b0);
        drain_pre();
        drain_post();
        imem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait fetch, back-to-back.
        pc_curr = 32'h0; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
        ep("zw0_pcwr", SPcWr, 32'd1);
        ep("zw0_req", SReq, 32'd1);
        ep("zw0_addr", SAddr, 32'h0);
        ifid("zw0", 32'h2008_0005, 32'h4, 1'b1);
        cycle();
        pc_curr = 32'h4; imem_rdata = 32'h1111_1111;
        ep("zw1_pcwr", SPcWr, 32'd1);
        ep("zw1_addr", SAddr, 32'h4);
        ifid("zw1", 32'h1111_1111, 32'h8, 1'b1);
        cycle();

        // Ready delayed 3 cycles at 0x40.
        pc_curr = 32'h40; imem_ready = 1'b0; imem_rdata = 32'hxxxx_xxxx;
        for (int i = 0; i < 3; i++) begin
            ep("wait_pcwr", SPcWr, 32'd0);
            ep("wait_addr", SAddr, 32'h40);
            ep("wait_req", SReq, 32'd1);
            eq("wait_valid", SValid, 32'd0);
            cycle();
        end
        imem_ready = 1'b1; imem_rdata = 32'h2222_2222;
        ep("wait_done_pcwr", SPcWr, 32'd1);
        ifid("wait_done", 32'h2222_2222, 32'h44, 1'b1);
        cycle();

        // Ready while stalled -> HELD for 2 cycles, then release.
        pc_curr = 32'h10; imem_rdata = 32'h8C09_0000; stall = 1'b1;
        ep("hold0_pcwr", SPcWr, 32'd0);
        ifid("hold0", 32'h2222_2222, 32'h44, 1'b1);
        cycle();
        imem_ready = 1'b0; imem_rdata = 32'h0;
        ep("hold1_req", SReq, 32'd0);
        ep("hold1_pcwr", SPcWr, 32'd0);
        ifid("hold1", 32'h2222_2222, 32'h44, 1'b1);
        cycle();
        stall = 1'b0;
        ep("hold_rel_req", SReq, 32'd0);
        ep("hold_rel_pcwr", SPcWr, 32'd1);
        ifid("hold_rel", 32'h8C09_0000, 32'h14, 1'b1);
        cycle();

        // Flush with a pending request at 0x20 -> DRAIN.
        pc_curr = 32'h20; imem_ready = 1'b0;
        eq("bubble_valid", SValid, 32'd0);
        cycle();
        flush = 1'b1;
        ep("fl_pcwr", SPcWr, 32'd1);
        ep("fl_addr", SAddr, 32'h20);
        ifid("fl", 32'h0, 32'h0, 1'b0);
        cycle();
        flush = 1'b0; pc_curr = 32'h80;
        ep("dr0_req", SReq, 32'd1);
        ep("dr0_addr", SAddr, 32'h20);
        ep("dr0_pcwr", SPcWr, 32'd0);
        eq("dr0_valid", SValid, 32'd0);
        cycle();
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        ep("dr1_addr", SAddr, 32'h20);
        ep("dr1_pcwr", SPcWr, 32'd0);
        ifid("dr1", 32'h0, 32'h0, 1'b0);
        cycle();
        imem_rdata = 32'h3333_3333;
        ep("post_dr_addr", SAddr, 32'h80);
        ep("post_dr_pcwr", SPcWr, 32'd1);
        ifid("post_dr", 32'h3333_3333, 32'h84, 1'b1);
        cycle();

        // Flush and stall together in HELD.
        pc_curr = 32'h90; imem_rdata = 32'h4444_4444; stall = 1'b1;
        eq("hf0_valid", SValid, 32'd1);
        cycle();
        flush = 1'b1; imem_ready = 1'b0;
        ep("hf1_req", SReq, 32'd0);
        ep("hf1_pcwr", SPcWr, 32'd1);
        ifid("hf1", 32'h0, 32'h0, 1'b0);
        cycle();
        flush = 1'b0; stall = 1'b0; pc_curr = 32'hA0;
        imem_ready = 1'b1; imem_rdata = 32'h5555_5555;
        ep("hf2_req", SReq, 32'd1);
        ep("hf2_addr", SAddr, 32'hA0);
        ep("hf2_pcwr", SPcWr, 32'd1);
        ifid("hf2", 32'h5555_5555, 32'hA4, 1'b1);
        cycle();

        // PC+4 wraparound.
        pc_curr = 32'hFFFF_FFFC; imem_rdata = 32'h6666_6666;
        ifid("wrap", 32'h6666_6666, 32'h0, 1'b1);
        cycle();

        // Reset pulsed mid-DRAIN.
        pc_curr = 32'h100; imem_ready = 1'b0; flush = 1'b1;
        ifid("fl2", 32'h0, 32'h0, 1'b0);
        cycle();
        flush = 1'b0;
        ep("dr2_addr", SAddr, 32'h100);
        ep("dr2_req", SReq, 32'd1);
        drain_pre();
        #2;
        reset = 1'b0; flush = 1'b1; imem_ready = 1'b1;
        #1;
        ep("rst_async_req", SReq, 32'd0);
        ep("rst_async_pcwr", SPcWr, 32'd0);
        ifid("rst_async", 32'h0, 32'h0, 1'b0);
        drain_pre();
        drain_post();
        pc_curr = 32'h200; flush = 1'b0; imem_ready = 1'b0;
        reset = 1'b1;
        // Back in REQ: address comes from pc_curr, not the old drain address.
        ep("rst_rel_req", SReq, 32'd1);
        ep("rst_rel_addr", SAddr, 32'h200);
        ep("rst_rel_pcwr", SPcWr, 32'd0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the PC register. It issues the current PC to instruction memory over a req/ready handshake and drives the PC register's write enable. It captures the returned instruction into the IF/ID pipeline register, honouring stall and flush from the hazard/branch logic. A one-entry hold buffer absorbs an instruction that returns while ID is stalled.

Parameters:
WORD, 32, datapath/address width
NOP, 32'h0000_0000, instruction injected into IF/ID on flush/reset (MIPS sll $0,$0,0)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
pc_curr  in  WORD  current PC from PC register
pc_write  out  1  write enable to PC register (PCWrite)
stall  in  1  ID cannot accept; IF/ID must hold
flush  in  1  branch/jump taken; discard fetch path, PC loads target this cycle
imem_req  out  1  fetch request valid
imem_addr  out  WORD  fetch address
imem_ready  in  1  memory completes transfer this cycle; imem_rdata valid
imem_rdata  in  WORD  fetched instruction
ifid_instr  out  WORD  IF/ID instruction
ifid_pc4  out  WORD  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset=0, async):
  - state=REQ; ifid_instr=NOP, ifid_pc4=0, ifid_valid=0; hold buffer and drain_addr cleared.
  - pc_write forced 0 and imem_req forced 0 while reset=0.
- Handshake: transfer occurs on a rising edge with imem_req=1 and imem_ready=1. imem_addr stays stable while imem_req=1 and ready=0. Zero-wait memory is legal (ready in the same cycle as req).
- pc_write is combinational from state and inputs; PC+4 = pc_curr + 4, mod 2^WORD (wraps at 32'hFFFF_FFFC -> 0).
- Priority in every state: flush > stall > normal.
- State REQ: imem_req=1, imem_addr=pc_curr.
  - flush & ready: data discarded; IF/ID <= {NOP, 0, valid 0}; pc_write=1; stay REQ.
  - flush & !ready: drain_addr <= pc_curr; IF/ID <= {NOP, 0, 0}; pc_write=1; -> DRAIN.
  - ready & !stall: IF/ID <= {imem_rdata, pc_curr+4, 1}; pc_write=1; stay REQ.
  - ready & stall: buffer <= imem_rdata; IF/ID held; pc_write=0; -> HELD.
  - !ready: pc_write=0; IF/ID held if stall, else IF/ID valid <= 0 (bubble).
- State HELD: imem_req=0; pc_curr is unchanged.
  - flush: buffer discarded; IF/ID <= {NOP, 0, 0}; pc_write=1; -> REQ.
  - !stall: IF/ID <= {buffer, pc_curr+4, 1}; pc_write=1; -> REQ.
  - stall: hold everything; pc_write=0.
- State DRAIN: imem_req=1, imem_addr=drain_addr; pc_write=0.
  - Waits for ready; returned data is always discarded; -> REQ on ready.
  - flush in DRAIN: pc_write=1 (new target); stay DRAIN.
  - IF/ID valid <= 0 unless stall (held).
- Throughput: 1 instruction/cycle with zero-wait memory and no stall. Fetch-to-IF/ID latency is one edge after ready.
- Asserting reset mid-transaction abandons any outstanding request; memory must tolerate req dropping.

Test Plan:
- Reset then pc_curr=0x0, ready tied 1, imem_rdata=0x2008_0005 -> after 1st edge ifid_instr=0x2008_0005, ifid_pc4=0x4, valid=1; pc_write=1 every cycle.
- Ready delayed 3 cycles at pc_curr=0x40 -> imem_addr=0x40 stable, pc_write=0 for 3 cycles, ifid_valid=0; 4th cycle pc_write=1, ifid_pc4=0x44.
- Ready & stall at pc_curr=0x10, rdata=0x8C09_0000, stall held 2 cycles -> HELD, imem_req=0, IF/ID unchanged; stall drops -> ifid_instr=0x8C09_0000, pc4=0x14, valid=1, pc_write=1.
- Flush while request pending at 0x20 (ready=0), then ready 2 cycles later with 0xDEAD_BEEF -> DRAIN with imem_addr=0x20, IF/ID={0,0,0}, data discarded, then REQ at the new pc_curr.
- Flush and stall together in HELD -> buffer dropped, ifid_valid=0, pc_write=1, state REQ.
- pc_curr=0xFFFF_FFFC fetch -> ifid_pc4=0x0; reset pulsed low mid-DRAIN -> IF/ID={NOP,0,0}, imem_req=0 immediately (async).
